uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLOCKS_PER_PULSE, default 4: clock cycles per serial bit; legal values >= 4.
REQ-002 SHALL have parameter BITS_PER_WORD, default 8: data bits per serial frame.
REQ-003 SHALL have parameter W_OUT, default 24: output packet width, an integer multiple of BITS_PER_WORD.
REQ-004 SHALL have localparam NUM_WORDS = W_OUT/BITS_PER_WORD, which is 3 at the defaults.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-008 SHALL have port m_data, output, [NUM_WORDS-1:0][BITS_PER_WORD-1:0]: assembled packet; word 0 is the first word received.
REQ-009 SHALL have port m_valid, output, 1 bit: m_data holds an unconsumed packet.
REQ-010 SHALL have port m_ready, input, 1 bit: downstream accepts the packet.
REQ-011 SHALL have ports err_frame and err_overflow, output, 1 bit each, present only under UART_RX_ERR_EN (see REQ-027).

Function
REQ-012 SHALL pass rx through a two-flop synchronizer; all logic below uses the synchronized value rxs.
- Added latency: 2 cycles.
REQ-013 SHALL accept frames formatted as: start bit (0), then BITS_PER_WORD data bits LSB first, then at least one stop bit (1).
- Extra stop bits are treated as idle.
REQ-014 SHALL implement states IDLE, START, DATA and STOP, each driven by a bit-clock counter c_clocks.
REQ-015 SHALL leave IDLE for START only on a falling edge of rxs (previous rxs=1, current rxs=0), and SHALL clear c_clocks on that transition.
- A line held low never retriggers.
REQ-016 SHALL, in START, sample rxs when c_clocks reaches CLOCKS_PER_PULSE/2-1.
- rxs=1: false start; return to IDLE.
- rxs=0: go to DATA and clear c_clocks.
REQ-017 SHALL, in DATA, sample rxs each time c_clocks reaches CLOCKS_PER_PULSE-1, shifting the sample into the word at bit index c_bits.
- After BITS_PER_WORD samples, go to STOP.
REQ-018 SHALL, in STOP, sample rxs once when c_clocks reaches CLOCKS_PER_PULSE-1, then go to IDLE.
- rxs=1: store the word into shadow slot c_words.
- rxs=0: framing error; discard all words of the current packet and clear c_words.
REQ-019 SHALL, when the stored word is slot NUM_WORDS-1, mark the packet complete and clear c_words.
REQ-020 SHALL, on packet complete with m_valid=0, copy the shadow into m_data and assert m_valid on the next cycle.
REQ-021 SHALL, on packet complete with m_valid=1 and m_ready=1 in the same cycle, load the new packet and keep m_valid=1.
REQ-022 SHALL, on packet complete with m_valid=1 and m_ready=0, drop the new packet and leave m_data unchanged (overflow).
REQ-023 SHALL hold m_data stable while m_valid=1 and m_ready=0, and SHALL clear m_valid one cycle after a cycle with m_valid&&m_ready when no packet completes in that cycle.
REQ-024 SHALL keep receiving serial frames regardless of m_ready; backpressure never stalls the line.

Reset
REQ-025 SHALL, when rst=1 at a clock edge, set: state=IDLE; c_clocks, c_bits, c_words=0; shadow and m_data=0; m_valid=0; err_frame, err_overflow=0; both synchronizer flops=1.
REQ-026 SHALL, on reset asserted mid-frame, abandon the partial packet; after rst deasserts, reception resumes only at the next falling edge.

Configuration
REQ-027 SHALL use macro UART_RX_ERR_EN to control error reporting.
- Defined: ports err_frame and err_overflow exist; each pulses high for exactly one cycle on a framing error (REQ-018) or an overflow (REQ-022).
- Undefined: the ports and their logic are absent; the error behaviour of REQ-018 and REQ-022 is unchanged.

Verification
REQ-028 SHALL cover one 3-word packet (defaults) with frames 0xA5, 0x3C, 0xFF and one stop bit each.
- Required: m_valid=1 and m_data={0xFF,0x3C,0xA5}, held until m_ready.
REQ-029 SHALL cover a 1-cycle low glitch on rx while idle.
- Required: false start, return to IDLE, no m_valid and no word stored.
REQ-030 SHALL cover a word 0x55 sent with stop bit=0, followed by three valid words 0x01, 0x02, 0x03.
- Required: err_frame pulses once; the delivered packet is {0x03,0x02,0x01}.
REQ-031 SHALL cover two full packets with m_ready held at 0.
- Required: m_data keeps the first packet; err_overflow pulses once when the second packet completes.
REQ-032 SHALL cover a packet completing in the same cycle as an m_valid&&m_ready handshake.
- Required: the new packet appears and m_valid stays high continuously.
REQ-033 SHALL cover rst asserted during the DATA state of word 1.
- Required: all outputs return to reset values; the next full packet is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// Serial receiver: assembles NUM_WORDS UART frames into one packet behind a valid/ready output.
// Optional macro UART_RX_ERR_EN adds one-cycle err_frame / err_overflow pulse outputs.

module uart_rx #(
    parameter int CLOCKS_PER_PULSE = 4,
    parameter int BITS_PER_WORD    = 8,
    parameter int W_OUT            = 24,
    localparam int NUM_WORDS       = W_OUT / BITS_PER_WORD
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    rx,
    output logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0] m_data,
    output logic                                    m_valid,
    input  logic                                    m_ready
`ifdef UART_RX_ERR_EN
    ,
    output logic                                    err_frame,
    output logic                                    err_overflow
`endif
);

    localparam int CW = $clog2(CLOCKS_PER_PULSE);
    localparam int BW = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
    localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                                  state_reg, state_next;
    logic                                    sync1_reg, rxs_reg, rxs_prev_reg;
    logic [CW-1:0]                           c_clocks_reg, c_clocks_next;
    logic [BW-1:0]                           c_bits_reg, c_bits_next;
    logic [WW-1:0]                           c_words_reg, c_words_next;
    logic [BITS_PER_WORD-1:0]                word_reg, word_next;
    logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0] shadow_reg, shadow_fill;
    logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0] m_data_reg;
    logic                                    m_valid_reg, m_valid_next;
    logic                                    half_end, bit_end;
    logic                                    store_word, complete, load;

    // rxs_prev_reg tracks the previous synchronized sample for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg    <= 1'b1;
            rxs_reg      <= 1'b1;
            rxs_prev_reg <= 1'b1;
        end else begin
            sync1_reg    <= rx;
            rxs_reg      <= sync1_reg;
            rxs_prev_reg <= rxs_reg;
        end
    end

    assign half_end = (c_clocks_reg == CW'(CLOCKS_PER_PULSE / 2 - 1));
    assign bit_end  = (c_clocks_reg == CW'(CLOCKS_PER_PULSE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            c_clocks_reg <= '0;
            c_bits_reg   <= '0;
            c_words_reg  <= '0;
            word_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            c_clocks_reg <= c_clocks_next;
            c_bits_reg   <= c_bits_next;
            c_words_reg  <= c_words_next;
            word_reg     <= word_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        c_clocks_next = c_clocks_reg + CW'(1);
        c_bits_next   = c_bits_reg;
        c_words_next  = c_words_reg;
        word_next     = word_reg;
        store_word    = 1'b0;
        complete      = 1'b0;
        case (state_reg)
            IDLE: begin
                c_clocks_next = '0;
                if (rxs_prev_reg && !rxs_reg) begin
                    state_next = START;
                end
            end
            START: begin
                if (half_end) begin
                    c_clocks_next = '0;
                    state_next    = rxs_reg ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    c_clocks_next         = '0;
                    word_next[c_bits_reg] = rxs_reg;
                    if (c_bits_reg == BW'(BITS_PER_WORD - 1)) begin
                        c_bits_next = '0;
                        state_next  = STOP;
                    end else begin
                        c_bits_next = c_bits_reg + BW'(1);
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    c_clocks_next = '0;
                    state_next    = IDLE;
                    if (rxs_reg) begin
                        store_word = 1'b1;
                        if (c_words_reg == WW'(NUM_WORDS - 1)) begin
                            complete     = 1'b1;
                            c_words_next = '0;
                        end else begin
                            c_words_next = c_words_reg + WW'(1);
                        end
                    end else begin
                        // Bad stop bit: restart the packet from slot 0
                        c_words_next = '0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shadow including the word being stored this cycle, so a completing packet copies whole
    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_slot
            assign shadow_fill[gi] = (store_word && c_words_reg == WW'(gi)) ? word_reg
                                                                           : shadow_reg[gi];
        end
    endgenerate

    assign load = complete && (!m_valid_reg || m_ready);

    always_comb begin
        m_valid_next = m_valid_reg;
        if (load) begin
            m_valid_next = 1'b1;
        end else if (m_valid_reg && m_ready) begin
            m_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_reg  <= '0;
            m_data_reg  <= '0;
            m_valid_reg <= 1'b0;
        end else begin
            shadow_reg  <= shadow_fill;
            m_valid_reg <= m_valid_next;
            if (load) begin
                m_data_reg <= shadow_fill;
            end
        end
    end

    assign m_data  = m_data_reg;
    assign m_valid = m_valid_reg;

`ifdef UART_RX_ERR_EN
    logic err_frame_reg, err_overflow_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_frame_reg    <= 1'b0;
            err_overflow_reg <= 1'b0;
        end else begin
            err_frame_reg    <= (state_reg == STOP) && bit_end && !rxs_reg;
            err_overflow_reg <= complete && m_valid_reg && !m_ready;
        end
    end

    assign err_frame    = err_frame_reg;
    assign err_overflow = err_overflow_reg;
`endif

endmodule
